// File: rtl/priority_decoder.sv
// priority_decoder: FIFO of index codes, head decoded to one-hot (thermometer when PRIORITY_DECODER_THERMO_EN is defined); ports clk, rst, in_valid/in_ready/in_code, out_valid/out_ready/out_data, fifo_count
module priority_decoder #(
  parameter int WIDTH = 4,
  parameter int CODE_W = $clog2(WIDTH),
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CODE_W-1:0]      in_code,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int PW = $clog2(DEPTH);
  logic [CODE_W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic push, pop;
  logic [CODE_W-1:0] head;
  assign in_ready = (fifo_count != (PW+1)'(DEPTH)) && !rst;
  assign out_valid = fifo_count != '0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign head = mem[rp];
`ifdef PRIORITY_DECODER_THERMO_EN
  assign out_data = out_valid ? {WIDTH{1'b1}} >> (CODE_W'(WIDTH - 1) - head) : '0;
`else
  assign out_data = out_valid ? WIDTH'(1) << head : '0;
`endif
  always_ff @(posedge clk)
    if (push) mem[wp] <= in_code;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      fifo_count <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_priority_decoder.sv
// tb_priority_decoder: vector table plus randomized queue-model check of priority_decoder
module tb_priority_decoder;
  localparam int W = 4;
  localparam int D = 4;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [1:0] in_code = '0;
  logic in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [2:0] fifo_count;
  int tests = 0, fails = 0;
  int q[$];
  typedef struct {
    logic r, v;
    logic [1:0] c;
    logic rd, ev;
    logic [1:0] ec;
    int en;
    logic er;
  } vec_t;
  vec_t tbl[$];

  priority_decoder #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] expand(input int code);
    logic [W-1:0] r = '0;
    for (int i = 0; i < W; i++)
`ifdef PRIORITY_DECODER_THERMO_EN
      r[i] = i <= code;
`else
      r[i] = i == code;
`endif
    return r;
  endfunction

  task automatic cmp(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic add(input logic r, v, input logic [1:0] c, input logic rd, ev,
                     input logic [1:0] ec, input int en, input logic er);
    vec_t t;
    t.r = r; t.v = v; t.c = c; t.rd = rd; t.ev = ev; t.ec = ec; t.en = en; t.er = er;
    tbl.push_back(t);
  endtask

  task automatic step(input logic r, v, input logic [1:0] c, input logic rd);
    bit acc, pp;
    rst = r; in_valid = v; in_code = c; out_ready = rd;
    @(posedge clk);
    if (r) q.delete();
    else begin
      acc = v && q.size() < D;
      pp = rd && q.size() > 0;
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(int'(c));
    end
    @(negedge clk);
  endtask

  task automatic chk_model(input string n);
    cmp({n, " count"}, int'(fifo_count), q.size());
    cmp({n, " valid"}, int'(out_valid), int'(q.size() > 0));
    cmp({n, " data"}, int'(out_data), q.size() > 0 ? int'(expand(q[0])) : 0);
    cmp({n, " ready"}, int'(in_ready), int'(!rst && q.size() < D));
  endtask

  initial begin
    add(1,0,0,0, 0,0,0,0); add(1,0,0,0, 0,0,0,0); add(0,0,0,0, 0,0,0,1);
    add(0,1,3,0, 1,3,1,1); add(0,0,0,0, 1,3,1,1); add(0,0,0,0, 1,3,1,1); add(0,0,0,1, 0,0,0,1);
    add(0,1,0,0, 1,0,1,1); add(0,1,1,0, 1,0,2,1); add(0,1,2,0, 1,0,3,1); add(0,1,3,0, 1,0,4,0);
    add(0,1,0,0, 1,0,4,0); add(0,1,0,1, 1,1,3,1); add(0,1,0,1, 1,2,3,1); add(0,0,0,1, 1,3,2,1);
    add(0,0,0,1, 1,0,1,1); add(0,0,0,1, 0,0,0,1);
    add(0,1,1,0, 1,1,1,1); add(0,1,2,0, 1,1,2,1); add(0,1,3,1, 1,2,2,1); add(0,0,0,1, 1,3,1,1);
    add(0,0,0,1, 0,0,0,1);
    add(0,1,1,0, 1,1,1,1); add(0,1,2,0, 1,1,2,1); add(0,1,3,0, 1,1,3,1); add(1,1,0,1, 0,0,0,0);
    add(0,1,2,0, 1,2,1,1); add(0,0,0,1, 0,0,0,1);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].rd);
      cmp($sformatf("vec%0d valid", i), int'(out_valid), int'(tbl[i].ev));
      cmp($sformatf("vec%0d data", i), int'(out_data), tbl[i].ev ? int'(expand(int'(tbl[i].ec))) : 0);
      cmp($sformatf("vec%0d count", i), int'(fifo_count), tbl[i].en);
      cmp($sformatf("vec%0d ready", i), int'(in_ready), int'(tbl[i].er));
    end
    step(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 2'($urandom_range(3)), 1);
      chk_model($sformatf("stream%0d", i));
      cmp($sformatf("stream%0d count<=1", i), int'(fifo_count <= 1), 1);
    end
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(29) == 0, $urandom_range(3) != 0, 2'($urandom_range(3)),
           $urandom_range(2) == 0);
      chk_model($sformatf("rand%0d", i));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
